sine_phase_to_amp: RTL
======================

Name: sine_phase_to_amp

Overview:
Phase-to-amplitude converter placed directly downstream of the 32-bit circular phase accumulator (CircularCounter32bit) in the sine wave generator.
- Truncates the accumulator's count_out to a table address.
- Uses quarter-wave symmetry to look up a signed sine sample.
- Registers results through a 3-stage valid-tagged pipeline that feeds the DAC/output stage.

Parameters:
PHASE_W, 32, input phase width; matches accumulator count_out.
ADDR_W, 10, quarter-table address width; full cycle = 4*2^ADDR_W points.
AMP_W, 16, signed output amplitude width.

Ports:
CLK  input  1  single clock for the whole block.
SCLR  input  1  synchronous, active-high reset.
phase_in  input  PHASE_W  accumulator phase (count_out).
phase_valid  input  1  phase_in is a valid sample this cycle.
sin_out  output  AMP_W  signed two's-complement sine sample.
amp_valid  output  1  sin_out (and cos_out) valid this cycle.
cos_out  output  AMP_W  cosine sample; present only with COS_OUT_EN.

Interface decision: one clock; reset is synchronous and active-high. The clock port is named CLK and the reset port is named SCLR.

Behaviour:
- Truncation: quadrant q = phase_in[PHASE_W-1 -: 2]; index a = phase_in[PHASE_W-3 -: ADDR_W]. Lower bits are discarded, with no rounding.
- Quarter ROM: 2^ADDR_W entries, unsigned, AMP_W-1 bits. Entry k = round((2^(AMP_W-1)-1) * sin((k+0.5)*pi/2^(ADDR_W+1))). The half-LSB offset makes mirroring exact.
- Stage 1 (registered): mirrored address m = q[0] ? ~a : a; neg flag = q[1]; v1 = phase_valid.
- Stage 2 (registered ROM read, block-RAM inferable): mag = ROM[m]; neg and valid are delayed alongside it.
- Stage 3 (registered): sin_out = neg ? -mag : +mag, sign-extended to AMP_W; amp_valid = v2.
  - The peak is 2^(AMP_W-1)-1, so negation cannot overflow.
  - -2^(AMP_W-1) is never produced.
- Latency: exactly 3 CLK cycles from phase_valid=1 to amp_valid=1.
- Throughput: one sample per cycle. There is no backpressure.
- Valid gaps propagate unchanged. When valid=0, data registers may hold or update; the bench checks data only when amp_valid=1.
- Reset: while SCLR=1 on a CLK edge, all valid bits and outputs go to 0 (sin_out=0, cos_out=0, amp_valid=0).
  - SCLR mid-stream drops all in-flight samples.
  - After release, the first amp_valid appears 3 cycles after the first phase_valid sampled with SCLR=0.
- SCLR and phase_valid asserted in the same cycle: SCLR wins and the sample is dropped.
- Wrap-around: phase 0xFFFFFFFF followed by 0x00000000 needs no special handling. The output is continuous (-25 then 25 at defaults).

Optional Feature:
Macro COS_OUT_EN.
- Defined:
  - cos_out port exists.
  - Cosine uses quadrant qc = q+1 (mod 4) on the same index a.
  - It is read through a second ROM read port, so the ROM is dual-port.
  - Its mirror and negate logic is identical to the sine path, and it shares the same latency and amp_valid.
- Undefined: cos_out port and second read port are absent; area is a single-port ROM.

Decomposition:
- Package sine_lut_pkg holds:
  - default PHASE_W/ADDR_W/AMP_W constants;
  - a quadrant encoding typedef (Q0..Q3);
  - a constant function computing quarter-ROM entry k, used for ROM init.
- One sub-module: sine_quarter_rom.
  - Registered-output ROM, one read port, second read port under COS_OUT_EN.
  - Initialised from the package function.

Test Plan (defaults):
- Reset check: SCLR=1 for 2 cycles, then phase 0x00000000 with valid=1 at cycle 0 -> amp_valid=1 first at cycle 3; sin_out=25 (cos_out=32767).
- Quadrant points: phases 0x00000000, 0x40000000, 0x80000000, 0xC0000000 back-to-back -> sin_out 25, 32767, -25, -32767 on consecutive cycles starting at latency 3.
- Mirror edges: 0x3FFFFFFF -> 32767; 0x7FFFFFFF -> 25; 0xBFFFFFFF -> -32767; 0xFFFFFFFF -> -25.
- Valid gaps: valid pattern 1,0,1,1,0 -> amp_valid pattern 1,0,1,1,0 delayed exactly 3 cycles.
- Mid-stream reset: drive the accumulator with increment 4000 (freq = 4000/2^32*f_CLK). Assert SCLR for 1 cycle mid-stream -> amp_valid=0 and sin_out=0 the next cycle; outputs resume 3 cycles after the next valid phase.
- Golden sweep: full accumulator stream, compared against a reference model (table + symmetry) -> bit-exact. Under COS_OUT_EN, cos_out(p) == sin_out(p+0x40000000).

Source files
------------

// File: rtl/sine_lut_pkg.sv
// Shared constants, quadrant encoding and quarter-wave table generator
// for the phase-to-amplitude converter.
package sine_lut_pkg;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_AMP_W   = 16;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_e;

    // Quarter-wave entry k, sampled at the half-step so that the mirrored
    // address ~k lands exactly on the reflected sample.
    function automatic int quarter_rom_entry(int k, int addr_w, int amp_w);
        real pi_r;
        real peak;
        real theta;
        pi_r  = 3.14159265358979323846;
        peak  = (2.0 ** (amp_w - 1)) - 1.0;
        theta = (real'(k) + 0.5) * pi_r / (2.0 ** (addr_w + 1));
        return $rtoi(peak * $sin(theta) + 0.5);
    endfunction

    // Odd quadrants walk the table backwards.
    function automatic logic quadrant_mirrors(quadrant_e q);
        return (q == Q1) || (q == Q3);
    endfunction

    // Second half of the cycle is the negated first half.
    function automatic logic quadrant_negates(quadrant_e q);
        return (q == Q2) || (q == Q3);
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine ROM with registered read data (block-RAM style).
// A second read port is present when COS_OUT_EN is defined.
module sine_quarter_rom
    import sine_lut_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int AMP_W  = DEF_AMP_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_a,
    output logic [AMP_W-2:0]  data_a
`ifdef COS_OUT_EN
    ,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [AMP_W-2:0]  data_b
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int ROM_W = AMP_W - 1;

    logic [ROM_W-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = ROM_W'(quarter_rom_entry(k, ADDR_W, AMP_W));
    end

    logic [ROM_W-1:0] data_a_d, data_a_q;

    // Port A read address decode.
    always_comb begin
        data_a_d = rom[addr_a];
    end

    // Port A output register; ROM data needs no reset.
    always_ff @(posedge clk) begin
        data_a_q <= data_a_d;
    end

    assign data_a = data_a_q;

`ifdef COS_OUT_EN
    logic [ROM_W-1:0] data_b_d, data_b_q;

    // Port B read address decode.
    always_comb begin
        data_b_d = rom[addr_b];
    end

    // Port B output register.
    always_ff @(posedge clk) begin
        data_b_q <= data_b_d;
    end

    assign data_b = data_b_q;
`endif

endmodule

// File: rtl/sine_phase_to_amp.sv
// Phase-to-amplitude converter: truncates accumulator phase, folds it onto
// a quarter-wave table and emits a signed sample three cycles later.
// Optional cosine output enabled by macro COS_OUT_EN.
module sine_phase_to_amp
    import sine_lut_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int AMP_W   = DEF_AMP_W
) (
    input  logic               CLK,
    input  logic               SCLR,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic               phase_valid,
    output logic [AMP_W-1:0]   sin_out,
    output logic               amp_valid
`ifdef COS_OUT_EN
    ,
    output logic [AMP_W-1:0]   cos_out
`endif
);

    quadrant_e         quad_s;
    logic [ADDR_W-1:0] idx;
    logic              unused_phase_lsbs;

    assign quad_s            = quadrant_e'(phase_in[PHASE_W-1 -: 2]);
    assign idx               = phase_in[PHASE_W-3 -: ADDR_W];
    assign unused_phase_lsbs = ^phase_in[PHASE_W-ADDR_W-3:0];

    logic [ADDR_W-1:0] addr_s1_d, addr_s1_q;
    logic              neg_s1_d, neg_s1_q, neg_s2_q;
    logic              v1_q, v2_q, amp_valid_q;
    logic [AMP_W-2:0]  mag_sin;
    logic [AMP_W-1:0]  sin_d, sin_q;

`ifdef COS_OUT_EN
    quadrant_e         quad_c;
    logic [ADDR_W-1:0] addr_c1_d, addr_c1_q;
    logic              neg_c1_d, neg_c1_q, neg_c2_q;
    logic [AMP_W-2:0]  mag_cos;
    logic [AMP_W-1:0]  cos_d, cos_q;

    assign quad_c = quadrant_e'(phase_in[PHASE_W-1 -: 2] + 2'd1);
`endif

    // Stage 1 combinational: quarter-wave folding of the table address.
    always_comb begin
        addr_s1_d = quadrant_mirrors(quad_s) ? ~idx : idx;
        neg_s1_d  = quadrant_negates(quad_s);
`ifdef COS_OUT_EN
        addr_c1_d = quadrant_mirrors(quad_c) ? ~idx : idx;
        neg_c1_d  = quadrant_negates(quad_c);
`endif
    end

    // Stage 3 combinational: apply sign; peak is 2^(AMP_W-1)-1 so no overflow.
    always_comb begin
        sin_d = neg_s2_q ? -{1'b0, mag_sin} : {1'b0, mag_sin};
`ifdef COS_OUT_EN
        cos_d = neg_c2_q ? -{1'b0, mag_cos} : {1'b0, mag_cos};
`endif
    end

    // Data pipeline registers; only meaningful alongside their valid bit.
    always_ff @(posedge CLK) begin
        addr_s1_q <= addr_s1_d;
        neg_s1_q  <= neg_s1_d;
        neg_s2_q  <= neg_s1_q;
`ifdef COS_OUT_EN
        addr_c1_q <= addr_c1_d;
        neg_c1_q  <= neg_c1_d;
        neg_c2_q  <= neg_c1_q;
`endif
    end

    // Valid chain and outputs; reset drops everything in flight.
    always_ff @(posedge CLK) begin
        if (SCLR) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            amp_valid_q <= 1'b0;
            sin_q       <= '0;
`ifdef COS_OUT_EN
            cos_q       <= '0;
`endif
        end else begin
            v1_q        <= phase_valid;
            v2_q        <= v1_q;
            amp_valid_q <= v2_q;
            sin_q       <= sin_d;
`ifdef COS_OUT_EN
            cos_q       <= cos_d;
`endif
        end
    end

    sine_quarter_rom #(
        .ADDR_W (ADDR_W),
        .AMP_W  (AMP_W)
    ) u_rom (
        .clk    (CLK),
        .addr_a (addr_s1_q),
        .data_a (mag_sin)
`ifdef COS_OUT_EN
        ,
        .addr_b (addr_c1_q),
        .data_b (mag_cos)
`endif
    );

    assign sin_out   = sin_q;
    assign amp_valid = amp_valid_q;
`ifdef COS_OUT_EN
    assign cos_out   = cos_q;
`endif

endmodule
